pipe_nodatahazards_if: RTL

Instruction-fetch stage of the five-stage pipeline; supplies `IFinst`/`IFp4` to the decode stage's instruction register and obeys that stage's stall (`IFwip`) and redirect (`IDwillJump`/`IDjumpPc`) outputs. It owns the PC and runs a req/ack handshake to instruction memory. A small prefetch buffer decouples memory latency from decode stalls. When no instruction is ready, it presents a NOP bubble.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_fetch_buf.sv | 42 ++++
 rtl/pipe_nodatahazards_if.sv | 105 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, IF FSM states, fetch-buffer entry.
// Prefetch depth is selected by the IF_PREFETCH_EN macro.
package pipe_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0340_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef IF_PREFETCH_EN
  localparam int unsigned IF_DEPTH = 2;
`else
  localparam int unsigned IF_DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] p4;
  } fetch_entry_t;

endpackage

// File: rtl/pipe_fetch_buf.sv
// Small shift-style FIFO holding fetched {inst, PC+4} pairs; flush wins over push/pop.
module pipe_fetch_buf
  import pipe_pkg::*;
#(
  parameter  int unsigned DEPTH = 1,
  localparam int unsigned CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  fetch_entry_t    wdata,
  output fetch_entry_t    head,
  output logic [CNTW-1:0] count
);

  fetch_entry_t    mem [DEPTH];
  logic [CNTW-1:0] wr_idx;

  // After a pop the entries shift down, so the write slot moves down with them.
  assign wr_idx = count - CNTW'(pop);
  assign head   = mem[0];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) mem[i] <= mem[i+1];
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (push && (CNTW'(i) == wr_idx)) mem[i] <= wdata;
      end
      count <= count + CNTW'(push) - CNTW'(pop);
    end
  end

endmodule

// File: rtl/pipe_nodatahazards_if.sv
// Instruction-fetch stage: PC, imem req/ack FSM, prefetch buffer, bubble insertion.
// IF_PREFETCH_EN selects a two-entry prefetch buffer (default: single holding register).
module pipe_nodatahazards_if
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        IFwip,
  input  logic        IDwillJump,
  input  logic [31:0] IDjumpPc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFinst,
  output logic [31:0] IFp4
);

  localparam int unsigned CNTW = $clog2(IF_DEPTH + 1);

  if_state_e       state_q, state_d;
  logic [31:0]     pc_q, pc_d, addr_d, jump_pc;
  logic            req_d;
  logic            push, pop, flush, head_valid;
  logic [CNTW-1:0] count;
  logic [CNTW:0]   count_post;
  fetch_entry_t    head, wdata;

  assign jump_pc    = {IDjumpPc[31:2], 2'b00};
  assign head_valid = (count != '0);

  // State, PC and registered memory-side outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IF_IDLE;
      pc_q      <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
    end
  end

  // Next state; issue is only allowed when a slot will be free so an ack always fits.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_post = (CNTW+1)'(count) + (CNTW+1)'(push) - (CNTW+1)'(pop);
    if (IDwillJump) pc_d = jump_pc;
    unique case (state_q)
      IF_IDLE: begin
        if (IDwillJump || (count_post < (CNTW+1)'(IF_DEPTH))) state_d = IF_REQ;
      end
      IF_REQ: begin
        if (imem_ack) begin
          if (!IDwillJump) begin
            pc_d = pc_q + 32'd4;
            if (count_post >= (CNTW+1)'(IF_DEPTH)) state_d = IF_IDLE;
          end
        end else if (IDwillJump) begin
          state_d = IF_DROP;
        end
      end
      IF_DROP: begin
        if (imem_ack) state_d = IF_REQ;
      end
      default: state_d = IF_IDLE;
    endcase
    // A dropped request keeps its address on the bus until memory acks it.
    addr_d = (state_d == IF_DROP) ? imem_addr : pc_d;
    req_d  = (state_d != IF_IDLE);
  end

  // Buffer controls and decode-facing outputs; a redirect forces a bubble.
  always_comb begin
    push       = (state_q == IF_REQ) && imem_ack && !IDwillJump;
    pop        = IFwip && head_valid && !IDwillJump;
    flush      = IDwillJump;
    wdata.inst = imem_rdata;
    wdata.p4   = pc_q + 32'd4;
    IFinst     = INST_NOP;
    IFp4       = pc_q + 32'd4;
    if (head_valid && !IDwillJump) begin
      IFinst = head.inst;
      IFp4   = head.p4;
    end
  end

  pipe_fetch_buf #(.DEPTH(IF_DEPTH)) u_buf (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

endmodule
